// File: rtl/config_emu_pkg.sv
// rtl/config_emu_pkg.sv - shared constants and helpers for the config shift-register emulator
package config_emu_pkg;

    localparam int CONFIG_REG_WIDTH_DEFAULT = 5164;
    localparam int SYNC_STAGES_DEFAULT      = 2;
    // Consecutive synchronized samples that must agree before the glitch
    // filter accepts a new ConfigClk/ConfigLoad level.
    localparam int GLITCH_STABLE_CYCLES     = 3;

    // Width needed to count 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/config_shift_reg_emulator_if.sv
// rtl/config_shift_reg_emulator_if.sv - serial configuration interface between driver and emulator
//
// Signals:
//   ConfigClk   serial clock (driver -> emulator)
//   Reset_not   chip-level active-low reset (driver -> emulator)
//   ConfigIn    serial data (driver -> emulator)
//   ConfigLoad  load strobe (driver -> emulator)
//   SuperpixSel select level (driver -> emulator)
//   ConfigOut   serial data out, shift-register MSB (emulator -> driver)
// Modports: master = driver side, slave = emulator side.
interface config_shift_reg_emulator_if;

    logic ConfigClk;
    logic Reset_not;
    logic ConfigIn;
    logic ConfigLoad;
    logic SuperpixSel;
    logic ConfigOut;

    modport master (
        output ConfigClk,
        output Reset_not,
        output ConfigIn,
        output ConfigLoad,
        output SuperpixSel,
        input  ConfigOut
    );

    modport slave (
        input  ConfigClk,
        input  Reset_not,
        input  ConfigIn,
        input  ConfigLoad,
        input  SuperpixSel,
        output ConfigOut
    );

endinterface

// File: rtl/config_emu_sync_edge.sv
// rtl/config_emu_sync_edge.sv - input synchronizer with optional glitch filter and rise pulse
//
// Ports:
//   clk, resetn  sole clock, synchronous active-low reset
//   async_in     asynchronous input
//   level        synchronized level (delayed to stay aligned with rise)
//   rise         one-cycle pulse on an accepted 0->1 transition
// Optional macro: CONFIG_EMU_GLITCH_FILTER_EN - accept a new level only after
// GLITCH_STABLE_CYCLES agreeing synchronized samples; adds 2 cycles of latency.
module config_emu_sync_edge
    import config_emu_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

`ifdef CONFIG_EMU_GLITCH_FILTER_EN
    localparam int HW = GLITCH_STABLE_CYCLES - 1;

    logic [HW-1:0] hist_q;
    logic          filt_q;
    logic          stable;

    // lvl plus the HW history samples form the stability window.
    assign stable = (hist_q == {HW{lvl}});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= (hist_q << 1) | HW'(lvl);
            if (stable) begin
                filt_q <= lvl;
            end
        end
    end

    // The oldest history sample lines data inputs up with the filtered edge.
    assign level = hist_q[HW-1];
    assign rise  = stable & lvl & ~filt_q;
`else
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign level = lvl;
    assign rise  = lvl & ~prev_q;
`endif

endmodule

// File: rtl/config_shift_reg_emulator.sv
// rtl/config_shift_reg_emulator.sv - FPGA-side emulator of the ASIC configuration shift register
//
// Ports:
//   S_AXI_ACLK     sole clock
//   S_AXI_ARESETN  synchronous active-low reset
//   cfg            serial config interface (slave modport)
//   ParallelOut    register image latched on ConfigLoad
//   sel_q          synchronized SuperpixSel
//   load_done      one-cycle pulse after each load
//   bit_count      bits shifted since last load/reset, saturating at CONFIG_REG_WIDTH
//   overflow       sticky: more than CONFIG_REG_WIDTH bits shifted since last load
// Optional macro: CONFIG_EMU_GLITCH_FILTER_EN - glitch-filter ConfigClk/ConfigLoad.
module config_shift_reg_emulator
    import config_emu_pkg::*;
#(
    parameter int CONFIG_REG_WIDTH = CONFIG_REG_WIDTH_DEFAULT,
    parameter int SYNC_STAGES      = SYNC_STAGES_DEFAULT,
    parameter int CNT_W            = cnt_w(CONFIG_REG_WIDTH)
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    config_shift_reg_emulator_if.slave  cfg,
    output logic [CONFIG_REG_WIDTH-1:0] ParallelOut,
    output logic                        sel_q,
    output logic                        load_done,
    output logic [CNT_W-1:0]            bit_count,
    output logic                        overflow
);

    localparam int W = CONFIG_REG_WIDTH;

    logic         clk_rise;
    logic         load_rise;
    logic         in_q;
    logic         rst_not_q;
    logic         rst_not_d;
    logic         run;
    logic         clk_level_unused;
    logic         load_level_unused;
    logic         in_rise_unused;
    logic         rst_rise_unused;
    logic         sel_rise_unused;
    logic [W-1:0] shift_reg;

    config_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(S_AXI_ACLK), .resetn(S_AXI_ARESETN), .async_in(cfg.ConfigClk),
        .level(clk_level_unused), .rise(clk_rise)
    );

    config_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk(S_AXI_ACLK), .resetn(S_AXI_ARESETN), .async_in(cfg.ConfigLoad),
        .level(load_level_unused), .rise(load_rise)
    );

    config_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in (
        .clk(S_AXI_ACLK), .resetn(S_AXI_ARESETN), .async_in(cfg.ConfigIn),
        .level(in_q), .rise(in_rise_unused)
    );

    config_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(S_AXI_ACLK), .resetn(S_AXI_ARESETN), .async_in(cfg.Reset_not),
        .level(rst_not_q), .rise(rst_rise_unused)
    );

    config_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(S_AXI_ACLK), .resetn(S_AXI_ARESETN), .async_in(cfg.SuperpixSel),
        .level(sel_q), .rise(sel_rise_unused)
    );

    // Reset_not and the edge detectors share the same pipeline depth, so a
    // rise that coincides with Reset_not release surfaces in the very cycle
    // rst_not_q goes high. Requiring one extra cycle of release masks it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_not_d <= 1'b0;
        end else begin
            rst_not_d <= rst_not_q;
        end
    end

    assign run = rst_not_q & rst_not_d;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || !run) begin
            shift_reg     <= '0;
            ParallelOut   <= '0;
            cfg.ConfigOut <= 1'b0;
            bit_count     <= '0;
            overflow      <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            load_done     <= load_rise;
            cfg.ConfigOut <= shift_reg[W-1];

            if (clk_rise) begin
                shift_reg <= {shift_reg[W-2:0], in_q};
            end

            // Load wins the counters; ParallelOut takes the pre-shift image
            // because shift_reg is only updated at the end of this cycle.
            if (load_rise) begin
                ParallelOut <= shift_reg;
                bit_count   <= clk_rise ? CNT_W'(1) : '0;
                overflow    <= 1'b0;
            end else if (clk_rise) begin
                if (bit_count == CNT_W'(W)) begin
                    overflow <= 1'b1;
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_config_shift_reg_emulator.sv
// tb/tb_config_shift_reg_emulator.sv - self-checking bench for config_shift_reg_emulator
module tb_config_shift_reg_emulator;
    import config_emu_pkg::*;

    localparam int W    = 16;
    localparam int S    = 2;
    localparam int CW   = cnt_w(W);
    localparam int HALF = 10;
`ifdef CONFIG_EMU_GLITCH_FILTER_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = S + 2 + EXTRA;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [W-1:0]  po;
    logic          sel_q;
    logic          load_done;
    logic [CW-1:0] bit_count;
    logic          overflow;

    config_shift_reg_emulator_if cfg();

    config_shift_reg_emulator #(.CONFIG_REG_WIDTH(W), .SYNC_STAGES(S)) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(resetn),
        .cfg(cfg),
        .ParallelOut(po),
        .sel_q(sel_q),
        .load_done(load_done),
        .bit_count(bit_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: every bit shifted since the register was last cleared,
    // the count since the last load, and the last latched image.
    bit           hist[$];
    int           n_since_load;
    logic [W-1:0] m_po;

    function automatic logic [W-1:0] img();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++)
            if (hist.size() > i) r[i] = hist[hist.size() - 1 - i];
        return r;
    endfunction

    function automatic int m_cnt();
        return (n_since_load > W) ? W : n_since_load;
    endfunction

    task automatic model_reset();
        hist.delete();
        n_since_load = 0;
        m_po = '0;
    endtask

    task automatic shift_bit(input bit b, input bit chk_lat);
        logic [W-1:0] t;
        logic old_msb, new_msb;
        @(negedge clk);
        cfg.ConfigIn = b;
        repeat (2) @(negedge clk);
        cfg.ConfigClk = 1'b1;
        t = img(); old_msb = t[W-1];
        hist.push_back(b); n_since_load++;
        t = img(); new_msb = t[W-1];
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk); #1;
            if (chk_lat && c == LAT - 1) begin
                tests_run++;
                if (cfg.ConfigOut !== old_msb) begin
                    tests_failed++;
                    $display("FAIL cout_early: got %b want %b", cfg.ConfigOut, old_msb);
                end
            end
            if (chk_lat && c == LAT) begin
                tests_run++;
                if (cfg.ConfigOut !== new_msb) begin
                    tests_failed++;
                    $display("FAIL cout_lat: got %b want %b", cfg.ConfigOut, new_msb);
                end
            end
        end
        @(negedge clk);
        cfg.ConfigClk = 1'b0;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic do_load();
        int pulses = 0;
        @(negedge clk);
        cfg.ConfigLoad = 1'b1;
        m_po = img();
        n_since_load = 0;
        repeat (2 * HALF) begin
            @(posedge clk); #1;
            if (load_done === 1'b1) pulses++;
        end
        @(negedge clk);
        cfg.ConfigLoad = 1'b0;
        repeat (HALF) @(negedge clk);
        tests_run += 4;
        if (pulses !== 1) begin tests_failed++; $display("FAIL load_done_pulses: got %0d want 1", pulses); end
        if (po !== m_po) begin tests_failed++; $display("FAIL load_po: got %h want %h", po, m_po); end
        if (bit_count !== '0) begin tests_failed++; $display("FAIL load_cnt: got %0d want 0", bit_count); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL load_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cfg.ConfigClk = 0; cfg.ConfigIn = 0; cfg.ConfigLoad = 0;
        cfg.Reset_not = 1; cfg.SuperpixSel = 1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if ({po, cfg.ConfigOut, bit_count, overflow, load_done, sel_q} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: po=%h cout=%b cnt=%0d ovf=%b ld=%b sel=%b want all 0",
                     po, cfg.ConfigOut, bit_count, overflow, load_done, sel_q);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        model_reset();
    endtask

    task automatic test_shift_load();
        logic [W-1:0] words[3];
        words[0] = 16'hA5C3;
        words[1] = W'($urandom);
        words[2] = W'($urandom);
        for (int k = 0; k < 3; k++) begin
            for (int i = W - 1; i >= 0; i--) shift_bit(words[k][i], 1'b0);
            tests_run += 2;
            if (bit_count !== CW'(m_cnt())) begin tests_failed++; $display("FAIL shift_cnt: got %0d want %0d", bit_count, m_cnt()); end
            if (overflow !== 1'b0) begin tests_failed++; $display("FAIL shift_ovf: got %b want 0", overflow); end
            do_load();
            tests_run++;
            if (po !== words[k]) begin tests_failed++; $display("FAIL shift_word: got %h want %h", po, words[k]); end
        end
    endtask

    task automatic test_latency();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) shift_bit(1'b1, 1'b0);
        for (int i = 0; i < W; i++) shift_bit(1'b0, 1'b1);
        tests_run++;
        if (cfg.ConfigOut !== 1'b0) begin tests_failed++; $display("FAIL cout_end: got %b want 0", cfg.ConfigOut); end
        r = W'($urandom);
        for (int i = W - 1; i >= 0; i--) shift_bit(r[i], 1'b1);
        do_load();
    endtask

    task automatic test_overflow();
        do_load();
        for (int i = 0; i < W + 1; i++) shift_bit(1'($urandom), 1'b0);
        tests_run += 2;
        if (bit_count !== CW'(W)) begin tests_failed++; $display("FAIL ovf_cnt: got %0d want %0d", bit_count, W); end
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        do_load();
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] pre, t;
        pre = W'($urandom);
        for (int i = W - 1; i >= 0; i--) shift_bit(pre[i], 1'b0);
        @(negedge clk);
        cfg.ConfigIn = 1'b1;
        repeat (2) @(negedge clk);
        cfg.ConfigClk = 1'b1;
        cfg.ConfigLoad = 1'b1;
        m_po = img();
        hist.push_back(1'b1);
        n_since_load = 1;
        repeat (HALF) @(posedge clk);
        #1;
        t = img();
        tests_run += 3;
        if (po !== pre) begin tests_failed++; $display("FAIL same_po: got %h want %h", po, pre); end
        if (bit_count !== CW'(1)) begin tests_failed++; $display("FAIL same_cnt: got %0d want 1", bit_count); end
        if (cfg.ConfigOut !== t[W-1]) begin tests_failed++; $display("FAIL same_cout: got %b want %b", cfg.ConfigOut, t[W-1]); end
        @(negedge clk);
        cfg.ConfigClk = 1'b0;
        cfg.ConfigLoad = 1'b0;
        repeat (HALF) @(negedge clk);
        do_load();
        tests_run++;
        if (po !== {pre[W-2:0], 1'b1}) begin tests_failed++; $display("FAIL same_shifted: got %h want %h", po, {pre[W-2:0], 1'b1}); end
    endtask

    task automatic test_reset_not();
        int pulses = 0;
        for (int i = 0; i < W; i++) shift_bit(1'($urandom), 1'b0);
        do_load();
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom), 1'b0);
        tests_run++;
        if (bit_count !== CW'(5)) begin tests_failed++; $display("FAIL rn_pre_cnt: got %0d want 5", bit_count); end
        @(negedge clk);
        cfg.Reset_not = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        tests_run++;
        if ({po, cfg.ConfigOut, bit_count, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL rn_clear: po=%h cout=%b cnt=%0d ovf=%b want all 0", po, cfg.ConfigOut, bit_count, overflow);
        end
        repeat (3) begin
            @(negedge clk); cfg.ConfigIn = 1'b1; cfg.ConfigClk = 1'b1; cfg.ConfigLoad = 1'b1;
            repeat (HALF) begin @(posedge clk); #1; if (load_done === 1'b1) pulses++; end
            @(negedge clk); cfg.ConfigClk = 1'b0; cfg.ConfigLoad = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        tests_run += 2;
        if (bit_count !== '0 || po !== '0) begin tests_failed++; $display("FAIL rn_ignore: cnt=%0d po=%h want 0", bit_count, po); end
        if (pulses !== 0) begin tests_failed++; $display("FAIL rn_load_done: got %0d pulses want 0", pulses); end
        @(negedge clk);
        cfg.Reset_not = 1'b1;
        cfg.ConfigClk = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
        tests_run++;
        if (bit_count !== '0) begin tests_failed++; $display("FAIL rn_release_edge: got %0d want 0", bit_count); end
        @(negedge clk);
        cfg.ConfigClk = 1'b0;
        repeat (HALF) @(negedge clk);
        model_reset();
        for (int i = 0; i < 3; i++) shift_bit(1'($urandom), 1'b0);
        do_load();
    endtask

    task automatic test_aresetn();
        for (int i = 0; i < W; i++) shift_bit(1'($urandom), 1'b0);
        do_load();
        for (int i = 0; i < 7; i++) shift_bit(1'($urandom), 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({po, cfg.ConfigOut, bit_count, overflow, load_done, sel_q} !== '0) begin
            tests_failed++;
            $display("FAIL aresetn_clear: po=%h cout=%b cnt=%0d ovf=%b ld=%b sel=%b want all 0",
                     po, cfg.ConfigOut, bit_count, overflow, load_done, sel_q);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        model_reset();
        tests_run++;
        if (sel_q !== 1'b1) begin tests_failed++; $display("FAIL aresetn_sel: got %b want 1", sel_q); end
        for (int i = 0; i < W; i++) shift_bit(1'($urandom), 1'b0);
        do_load();
    endtask

    task automatic test_sel();
        logic v;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v = ~sel_q;
            cfg.SuperpixSel = v;
            for (int c = 1; c <= S + EXTRA; c++) begin
                @(posedge clk); #1;
                if (c == S + EXTRA - 1) begin
                    tests_run++;
                    if (sel_q !== ~v) begin tests_failed++; $display("FAIL sel_early: got %b want %b", sel_q, ~v); end
                end
                if (c == S + EXTRA) begin
                    tests_run++;
                    if (sel_q !== v) begin tests_failed++; $display("FAIL sel_lat: got %b want %b", sel_q, v); end
                end
            end
            repeat (3) @(negedge clk);
        end
    endtask

`ifdef CONFIG_EMU_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic [CW-1:0] before;
        logic          b;
        before = bit_count;
        b = 1'($urandom);
        @(negedge clk);
        cfg.ConfigIn = b;
        repeat (2) @(negedge clk);
        cfg.ConfigClk = 1'b1;
        repeat (2) @(negedge clk);
        cfg.ConfigClk = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        tests_run++;
        if (bit_count !== before) begin tests_failed++; $display("FAIL glitch_short: got %0d want %0d", bit_count, before); end
        cfg.ConfigClk = 1'b1;
        hist.push_back(b); n_since_load++;
        repeat (6) @(negedge clk);
        cfg.ConfigClk = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        tests_run++;
        if (bit_count !== CW'(m_cnt())) begin tests_failed++; $display("FAIL glitch_long: got %0d want %0d", bit_count, m_cnt()); end
        do_load();
    endtask
`endif

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, W + 3);
            for (int i = 0; i < n; i++) shift_bit(1'($urandom), 1'b0);
            tests_run += 2;
            if (bit_count !== CW'(m_cnt())) begin tests_failed++; $display("FAIL b2b_cnt: got %0d want %0d", bit_count, m_cnt()); end
            if (overflow !== (n_since_load > W)) begin tests_failed++; $display("FAIL b2b_ovf: got %b want %b", overflow, n_since_load > W); end
            do_load();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_shift_load();
        test_latency();
        test_overflow();
        test_same_cycle();
        test_reset_not();
        test_aresetn();
        test_sel();
`ifdef CONFIG_EMU_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
